// File: rtl/layer_compositor_if.sv
// Pixel/control bundle between a video source and the layer compositor.
interface layer_compositor_if #(
   parameter int unsigned N_LAYERS = 4,
   parameter int unsigned CIDXW    = 3
);
   logic                         pix_en;
   logic                         frame;
   logic [N_LAYERS*CIDXW-1:0]    layer_pix;
   logic [CIDXW-1:0]             overlay_pix;
   logic                         clear_fail;
   logic [CIDXW-1:0]             out_pix;
   logic                         out_valid;
   logic                         hit_pulse;
   logic                         fail;
   logic [N_LAYERS-1:0]          collide_map;
   logic [15:0]                  hit_count;

   modport master (
      output pix_en, frame, layer_pix, overlay_pix, clear_fail,
      input  out_pix, out_valid, hit_pulse, fail, collide_map, hit_count
   );

   modport slave (
      input  pix_en, frame, layer_pix, overlay_pix, clear_fail,
      output out_pix, out_valid, hit_pulse, fail, collide_map, hit_count
   );
endinterface

// File: rtl/layer_compositor.sv
// Priority layer compositor with per-frame player/hazard collision judging.
module layer_compositor #(
   parameter int unsigned N_LAYERS    = 4,
   parameter int unsigned CIDXW       = 3,
   parameter int unsigned HAZARD_MASK = 4'b0110,
   parameter int unsigned HIT_THRESH  = 4
) (
   input  logic               Clk,
   input  logic               Reset_n,
   layer_compositor_if.slave  bus_io
);
   localparam int unsigned CNTW = 16;
   localparam logic [CNTW-1:0] CNT_MAX = '1;
   // Layer 0 is the player and can never be its own hazard.
   localparam logic [N_LAYERS-1:0] HZ = N_LAYERS'(HAZARD_MASK) & ~N_LAYERS'(1);

   if (N_LAYERS < 2 || N_LAYERS > 8) begin : g_bad_layers
      $error("layer_compositor: N_LAYERS must be in 2..8");
   end
   if (CIDXW < 1) begin : g_bad_cidxw
      $error("layer_compositor: CIDXW must be at least 1");
   end
   if (HIT_THRESH < 1 || HIT_THRESH > 65535) begin : g_bad_thresh
      $error("layer_compositor: HIT_THRESH must be in 1..65535");
   end

   typedef enum logic [1:0] {ST_ARMED, ST_RUN, ST_FAILED} state_e;

   state_e               state_q, state_d;
   logic [N_LAYERS-1:0]  nz_c, hit_bits_c;
   logic [CIDXW-1:0]     comp_c;
   logic                 coll_c, judge_hit_c;
   logic [CNTW-1:0]      frame_hits_q, frame_hits_d, hit_count_q, hit_count_d;
   logic [N_LAYERS-1:0]  frame_map_q, frame_map_d, collide_map_q, collide_map_d;
   logic [CIDXW-1:0]     out_pix_q, out_pix_d;
   logic                 out_valid_q, out_valid_d, hit_pulse_q, hit_pulse_d, fail_q, fail_d;

   // Per-pixel priority select and collision detection.
   always_comb begin
      nz_c   = '0;
      comp_c = '0;
      for (int i = int'(N_LAYERS) - 1; i >= 0; i--) begin
         nz_c[i] = |bus_io.layer_pix[i*CIDXW +: CIDXW];
         if (nz_c[i]) comp_c = bus_io.layer_pix[i*CIDXW +: CIDXW];
      end
      coll_c      = bus_io.pix_en & nz_c[0] & (|(nz_c & HZ));
      hit_bits_c  = coll_c ? (nz_c & HZ) : '0;
      judge_hit_c = (frame_hits_q >= CNTW'(HIT_THRESH));
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (!Reset_n) state_q <= ST_ARMED;
      else          state_q <= state_d;
   end

   // Next-state: clear_fail wins over any frame judgement.
   always_comb begin
      state_d = state_q;
      if (bus_io.clear_fail) begin
         state_d = ST_ARMED;
      end else if (bus_io.frame) begin
         case (state_q)
            ST_ARMED: state_d = ST_RUN;
            ST_RUN:   if (judge_hit_c) state_d = ST_FAILED;
            default:  state_d = state_q;
         endcase
      end
   end

   // Output/datapath next values; the pixel on a frame strobe opens the new frame.
   always_comb begin
      out_pix_d     = bus_io.pix_en ? (comp_c | bus_io.overlay_pix) : out_pix_q;
      out_valid_d   = bus_io.pix_en;
      hit_pulse_d   = 1'b0;
      hit_count_d   = hit_count_q;
      collide_map_d = collide_map_q;
      frame_hits_d  = frame_hits_q;
      frame_map_d   = frame_map_q;
      fail_d        = (state_d == ST_FAILED);
      if (bus_io.clear_fail) begin
         collide_map_d = '0;
         frame_hits_d  = '0;
         frame_map_d   = '0;
      end else if (bus_io.frame) begin
         if (state_q == ST_RUN) begin
            collide_map_d = frame_map_q;
            if (judge_hit_c) begin
               hit_pulse_d = 1'b1;
               if (hit_count_q != CNT_MAX) hit_count_d = hit_count_q + CNTW'(1);
            end
         end
         if (state_d == ST_RUN) begin
            frame_hits_d = CNTW'(coll_c);
            frame_map_d  = hit_bits_c;
         end else begin
            frame_hits_d = '0;
            frame_map_d  = '0;
         end
      end else if (state_q == ST_RUN) begin
         if (coll_c && frame_hits_q != CNT_MAX) frame_hits_d = frame_hits_q + CNTW'(1);
         frame_map_d = frame_map_q | hit_bits_c;
      end
   end

   // Registered outputs and frame accumulators.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         out_pix_q     <= '0;
         out_valid_q   <= 1'b0;
         hit_pulse_q   <= 1'b0;
         fail_q        <= 1'b0;
         collide_map_q <= '0;
         hit_count_q   <= '0;
         frame_hits_q  <= '0;
         frame_map_q   <= '0;
      end else begin
         out_pix_q     <= out_pix_d;
         out_valid_q   <= out_valid_d;
         hit_pulse_q   <= hit_pulse_d;
         fail_q        <= fail_d;
         collide_map_q <= collide_map_d;
         hit_count_q   <= hit_count_d;
         frame_hits_q  <= frame_hits_d;
         frame_map_q   <= frame_map_d;
      end
   end

   assign bus_io.out_pix     = out_pix_q;
   assign bus_io.out_valid   = out_valid_q;
   assign bus_io.hit_pulse   = hit_pulse_q;
   assign bus_io.fail        = fail_q;
   assign bus_io.collide_map = collide_map_q;
   assign bus_io.hit_count   = hit_count_q;
endmodule

// File: tb/tb_layer_compositor.sv
// Randomized and directed checks of layer_compositor against a frame-level model.
module tb_layer_compositor;
   localparam int MD_ARMED  = 0;
   localparam int MD_RUN    = 1;
   localparam int MD_FAILED = 2;
   localparam int THRESH    = 4;

   localparam logic [11:0] L_PRIO   = {3'd0, 3'd3, 3'd5, 3'd0};
   localparam logic [11:0] L_COLL   = {3'd0, 3'd4, 3'd0, 3'd1};
   localparam logic [11:0] L_MASKED = {3'd2, 3'd0, 3'd0, 3'd1};

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   layer_compositor_if #(.N_LAYERS(4), .CIDXW(3)) bus ();

   layer_compositor #(
      .N_LAYERS(4), .CIDXW(3), .HAZARD_MASK(4'b0110), .HIT_THRESH(THRESH)
   ) dut (
      .Clk(clk),
      .Reset_n(rst_n),
      .bus_io(bus.slave)
   );

   int total = 0;
   int bad = 0;

   // model of observable behaviour
   int          m_mode = MD_ARMED;
   int          m_acc = 0;
   logic [3:0]  m_accmap = '0;
   logic [2:0]  m_pix = '0;
   logic        m_valid = 1'b0;
   logic        m_hit = 1'b0;
   logic        m_fail = 1'b0;
   logic [3:0]  m_map = '0;
   logic [15:0] m_cnt = '0;

   logic [25:0] obs, expv;
   assign obs  = {bus.out_pix, bus.out_valid, bus.hit_pulse, bus.fail, bus.collide_map, bus.hit_count};
   assign expv = {m_pix, m_valid, m_hit, m_fail, m_map, m_cnt};

   task automatic set_inputs(input bit pe, input bit fr, input logic [11:0] lp,
                             input logic [2:0] ov, input bit cf);
      bus.pix_en = pe; bus.frame = fr; bus.layer_pix = lp;
      bus.overlay_pix = ov; bus.clear_fail = cf;
   endtask

   // Drive one clock of inputs and advance the model by one cycle.
   task automatic drive(input bit pe, input bit fr, input logic [11:0] lp,
                        input logic [2:0] ov, input bit cf);
      logic [2:0] li [4];
      logic [2:0] top;
      bit         found, coll;
      logic [3:0] bits;
      int         old;
      set_inputs(pe, fr, lp, ov, cf);
      for (int i = 0; i < 4; i++) li[i] = lp[i*3 +: 3];
      top = 3'd0; found = 0;
      for (int i = 0; i < 4; i++) if (!found && li[i] != 3'd0) begin top = li[i]; found = 1; end
      coll = pe && li[0] != 3'd0 && (li[1] != 3'd0 || li[2] != 3'd0);
      bits = coll ? {1'b0, li[2] != 3'd0, li[1] != 3'd0, 1'b0} : 4'b0;
      m_valid = pe;
      if (pe) m_pix = top | ov;
      m_hit = 1'b0;
      old = m_mode;
      if (cf) begin
         m_mode = MD_ARMED; m_map = '0; m_acc = 0; m_accmap = '0;
      end else if (fr) begin
         if (old == MD_RUN) begin
            m_map = m_accmap;
            if (m_acc >= THRESH) begin
               m_hit = 1'b1;
               if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
               m_mode = MD_FAILED;
            end
         end else if (old == MD_ARMED) begin
            m_mode = MD_RUN;
         end
         if (m_mode == MD_RUN) begin m_acc = coll ? 1 : 0; m_accmap = bits; end
         else begin m_acc = 0; m_accmap = '0; end
      end else if (old == MD_RUN) begin
         if (coll && m_acc < 65535) m_acc++;
         m_accmap |= bits;
      end
      m_fail = (m_mode == MD_FAILED);
      @(posedge clk); #1;
   endtask

   task automatic apply_reset(input bit pe, input bit fr, input logic [11:0] lp);
      rst_n = 1'b0;
      set_inputs(pe, fr, lp, 3'd5, 1'b0);
      @(posedge clk); #1;
      m_mode = MD_ARMED; m_acc = 0; m_accmap = '0; m_pix = '0; m_valid = 0;
      m_hit = 0; m_fail = 0; m_map = '0; m_cnt = '0;
      rst_n = 1'b1;
      set_inputs(0, 0, '0, '0, 0);
   endtask

   task automatic test_reset();
      apply_reset(1, 1, L_COLL);
      total++;
      if (obs !== 26'd0) begin bad++; $display("FAIL reset_state: got %h want %h", obs, 26'd0); end
   endtask

   task automatic test_priority();
      drive(1, 0, L_PRIO, 3'd0, 0);
      total++;
      if (bus.out_pix !== 3'd5 || bus.out_valid !== 1'b1) begin
         bad++; $display("FAIL prio_pix: got pix=%0d valid=%b want pix=5 valid=1", bus.out_pix, bus.out_valid);
      end
      drive(0, 0, L_PRIO, 3'd0, 0);
      total++;
      if (bus.out_pix !== 3'd5 || bus.out_valid !== 1'b0) begin
         bad++; $display("FAIL prio_hold: got pix=%0d valid=%b want pix=5 valid=0", bus.out_pix, bus.out_valid);
      end
      drive(1, 0, L_PRIO, 3'd2, 0);
      total++;
      if (bus.out_pix !== 3'd7) begin bad++; $display("FAIL prio_overlay: got %0d want 7", bus.out_pix); end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL prio_model: got %h want %h", obs, expv); end
   endtask

   task automatic test_threshold();
      drive(0, 1, '0, 3'd0, 0);
      repeat (3) drive(1, 0, L_COLL, 3'd0, 0);
      drive(0, 1, '0, 3'd0, 0);
      total++;
      if (bus.hit_pulse !== 1'b0 || bus.collide_map !== 4'b0100 || bus.fail !== 1'b0) begin
         bad++; $display("FAIL thresh_below: got hit=%b map=%b fail=%b want 0 0100 0",
                         bus.hit_pulse, bus.collide_map, bus.fail);
      end
      repeat (4) drive(1, 0, L_COLL, 3'd0, 0);
      drive(0, 1, '0, 3'd0, 0);
      total++;
      if (bus.hit_pulse !== 1'b1 || bus.fail !== 1'b1 || bus.hit_count !== 16'd1) begin
         bad++; $display("FAIL thresh_hit: got hit=%b fail=%b cnt=%0d want 1 1 1",
                         bus.hit_pulse, bus.fail, bus.hit_count);
      end
      drive(0, 0, '0, 3'd0, 0);
      total++;
      if (bus.hit_pulse !== 1'b0 || bus.fail !== 1'b1) begin
         bad++; $display("FAIL thresh_pulse_width: got hit=%b fail=%b want 0 1", bus.hit_pulse, bus.fail);
      end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL thresh_model: got %h want %h", obs, expv); end
   endtask

   task automatic test_masking();
      drive(0, 0, '0, 3'd0, 1);
      total++;
      if (bus.fail !== 1'b0 || bus.collide_map !== 4'b0) begin
         bad++; $display("FAIL clear_fail: got fail=%b map=%b want 0 0000", bus.fail, bus.collide_map);
      end
      drive(0, 1, '0, 3'd0, 0);
      repeat (100) drive(1, 0, L_MASKED, 3'd0, 0);
      drive(0, 1, '0, 3'd0, 0);
      total++;
      if (bus.hit_pulse !== 1'b0 || bus.collide_map !== 4'b0 || bus.fail !== 1'b0) begin
         bad++; $display("FAIL masking: got hit=%b map=%b fail=%b want 0 0000 0",
                         bus.hit_pulse, bus.collide_map, bus.fail);
      end
   endtask

   task automatic test_boundary();
      logic [15:0] cnt_before;
      repeat (3) drive(1, 0, L_COLL, 3'd0, 0);
      drive(1, 1, L_COLL, 3'd0, 0);
      total++;
      if (bus.hit_pulse !== 1'b0 || bus.collide_map !== 4'b0100) begin
         bad++; $display("FAIL bound_frame_pix_old: got hit=%b map=%b want 0 0100", bus.hit_pulse, bus.collide_map);
      end
      repeat (3) drive(1, 0, L_COLL, 3'd0, 0);
      drive(0, 1, '0, 3'd0, 0);
      total++;
      if (bus.hit_pulse !== 1'b1 || bus.fail !== 1'b1) begin
         bad++; $display("FAIL bound_frame_pix_new: got hit=%b fail=%b want 1 1", bus.hit_pulse, bus.fail);
      end
      drive(0, 0, '0, 3'd0, 1);
      drive(0, 1, '0, 3'd0, 0);
      repeat (4) drive(1, 0, L_COLL, 3'd0, 0);
      cnt_before = bus.hit_count;
      drive(0, 1, '0, 3'd0, 1);
      total++;
      if (bus.hit_pulse !== 1'b0 || bus.hit_count !== cnt_before || bus.fail !== 1'b0 ||
          bus.collide_map !== 4'b0) begin
         bad++; $display("FAIL bound_clear_vs_frame: got hit=%b cnt=%0d fail=%b map=%b want 0 %0d 0 0000",
                         bus.hit_pulse, bus.hit_count, bus.fail, bus.collide_map, cnt_before);
      end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL bound_model: got %h want %h", obs, expv); end
   endtask

   task automatic test_random();
      logic [11:0] lp;
      bit prev_hit = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int l = 0; l < 4; l++) lp[l*3 +: 3] = ($urandom % 2 == 0) ? 3'($urandom) : 3'd0;
         drive($urandom % 4 != 0, $urandom % 40 == 0, lp,
               ($urandom % 4 == 0) ? 3'($urandom) : 3'd0, $urandom % 120 == 0);
         total++;
         if (obs !== expv) begin bad++; $display("FAIL random_cycle %0d: got %h want %h", n, obs, expv); end
         total++;
         if (prev_hit && bus.hit_pulse) begin bad++; $display("FAIL random_pulse_twice: got 1 want 0"); end
         prev_hit = bus.hit_pulse;
      end
   endtask

   task automatic test_saturation();
      logic [15:0] want;
      drive(0, 0, '0, 3'd0, 1);
      force dut.hit_count_q = 16'hFFFD;
      drive(0, 0, '0, 3'd0, 0);
      release dut.hit_count_q;
      m_cnt = 16'hFFFD;
      for (int k = 0; k < 3; k++) begin
         drive(0, 0, '0, 3'd0, 1);
         drive(0, 1, '0, 3'd0, 0);
         repeat (4) drive(1, 0, L_COLL, 3'd0, 0);
         drive(0, 1, '0, 3'd0, 0);
         want = (k == 0) ? 16'hFFFE : 16'hFFFF;
         total++;
         if (bus.hit_count !== want || bus.hit_pulse !== 1'b1) begin
            bad++; $display("FAIL saturate_%0d: got cnt=%h hit=%b want %h 1", k, bus.hit_count, bus.hit_pulse, want);
         end
      end
      total++;
      if (obs !== expv) begin bad++; $display("FAIL saturate_model: got %h want %h", obs, expv); end
   endtask

   task automatic test_reset_failed();
      drive(0, 0, '0, 3'd0, 1);
      drive(0, 1, '0, 3'd0, 0);
      repeat (5) drive(1, 0, L_COLL, 3'd1, 0);
      drive(0, 1, '0, 3'd0, 0);
      repeat (2) drive(1, 0, L_COLL, 3'd1, 0);
      total++;
      if (bus.fail !== 1'b1) begin bad++; $display("FAIL pre_reset_failed: got fail=%b want 1", bus.fail); end
      apply_reset(1, 1, L_COLL);
      total++;
      if (obs !== 26'd0) begin bad++; $display("FAIL reset_in_failed: got %h want %h", obs, 26'd0); end
      drive(0, 1, '0, 3'd0, 0);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL post_reset_model: got %h want %h", obs, expv); end
   endtask

   initial begin
      set_inputs(0, 0, '0, '0, 0);
      test_reset();
      test_priority();
      test_threshold();
      test_masking();
      test_boundary();
      test_random();
      test_saturation();
      test_reset_failed();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/layer_compositor.md
LAYER_COMPOSITOR -- requirements
Module: layer_compositor

Interface
REQ-001 Parameter N_LAYERS, default 4: number of sprite/background layers, 2..8; layer 0 is highest priority and is the player layer.
REQ-002 Parameter CIDXW, default 3: colour-index width per layer.
REQ-003 Parameter HAZARD_MASK, default 4'b0110: bit i set marks layer i as a hazard; bit 0 is ignored.
REQ-004 Parameter HIT_THRESH, default 4: collision pixels per frame required to declare a hit, 1..65535.
REQ-005 Clk  input  1  system clock; one clock; all logic on rising edge.
REQ-006 Reset_n  input  1  synchronous, active-low reset.
REQ-007 pix_en  input  1  pixel strobe (clk25-rate enable); pixel inputs are valid only when high.
REQ-008 frame  input  1  one-Clk start-of-frame pulse.
REQ-009 layer_pix  input  N_LAYERS*CIDXW  packed colour indices; layer i at bits [i*CIDXW +: CIDXW]; 0 = transparent.
REQ-010 overlay_pix  input  CIDXW  score/text overlay, ORed onto the composite.
REQ-011 clear_fail  input  1  level-sampled request to leave FAILED.
REQ-012 out_pix  output  CIDXW  composited colour index.
REQ-013 out_valid  output  1  out_pix updated this cycle.
REQ-014 hit_pulse  output  1  one-Clk pulse when a frame is judged a hit.
REQ-015 fail  output  1  high while in FAILED.
REQ-016 collide_map  output  N_LAYERS  hazard layers that touched the player in the last judged frame.
REQ-017 hit_count  output  16  number of hit frames since reset, saturating.

Function
REQ-018 Compositing: on a cycle with pix_en=1, out_pix SHALL register (lowest-index non-zero layer value, else 0) OR overlay_pix; out_valid SHALL be 1 the following cycle only; latency 1 Clk.
REQ-019 out_pix SHALL hold its value on cycles with pix_en=0.
REQ-020 Collision pixel: pix_en=1, layer 0 non-zero, and at least one HAZARD_MASK layer non-zero.
REQ-021 frame_hits (16-bit, saturating at 65535) SHALL count collision pixels in the current frame; frame_map SHALL OR in each colliding hazard layer bit.
REQ-022 A pixel sampled in the same cycle as frame SHALL belong to the new frame: frame_hits restarts at 1 (or 0), and frame_map at that pixel's bits (or 0).
REQ-023 FSM states ARMED, RUN, FAILED; reset state ARMED.
REQ-024 ARMED: frame -> RUN; no collision accumulation (discards the partial first frame).
REQ-025 RUN: on frame, collide_map <= frame_map; if frame_hits >= HIT_THRESH then hit_pulse=1 the next cycle, hit_count increments (holds at 16'hFFFF), go to FAILED; otherwise stay in RUN.
REQ-026 FAILED: fail=1; accumulation stops; collide_map holds; compositing continues.
REQ-027 clear_fail=1 in any state -> ARMED next cycle; clear_fail takes priority over a simultaneous frame judgement (no hit_pulse, no hit_count change); collide_map cleared to 0.
REQ-028 hit_pulse SHALL never be high for two consecutive cycles.
REQ-029 Parameter values outside the legal ranges SHALL be rejected at elaboration.

Reset
REQ-030 Reset_n=0 at a rising edge: state ARMED; out_pix=0; out_valid=0; hit_pulse=0; fail=0; collide_map=0; hit_count=0; frame_hits=0; frame_map=0.
REQ-031 Reset SHALL override every other input, including mid-frame and in FAILED.

Verification
REQ-032 Priority: layers {0,5,3,0} (L0..L3), overlay 0, pix_en=1 -> out_pix=5 one cycle later, out_valid=1 for that one cycle; with overlay=2 -> out_pix=7.
REQ-033 Threshold: HIT_THRESH=4, RUN, 3 collision pixels of L0=1 with L2=4, then frame -> no hit_pulse, collide_map=4'b0100, state remains RUN; next frame with 4 such pixels -> hit_pulse for 1 cycle, fail=1, hit_count=1.
REQ-034 Masking: L0 overlapping only L3 (mask bit clear), 100 pixels, then frame -> no hit, collide_map=0.
REQ-035 Boundaries: frame coincident with a collision pixel -> that pixel counted in the new frame; clear_fail coincident with a qualifying frame -> ARMED, hit_count unchanged, no hit_pulse.
REQ-036 Saturation/reset: force hit_count to 16'hFFFF via repeated hits -> stays 16'hFFFF; Reset_n=0 mid-frame in FAILED -> all outputs are at their reset values the next cycle.
